var_timestep_lpf_mc: RTL

- Multi-channel, variable-timestep, first-order low-pass model for emulation.
- Per transaction, applies y_i += (x_i - y_i) * alpha_i, with alpha_i = min(dt * k_i, 1.0).
- Channels are time-multiplexed through one update datapath.
- Also accumulates emulated time.
- Sits where the per-step analog model lives, between the stimulus/timestep generator and the output monitor.

---
 rtl/var_timestep_lpf_mc_pkg.sv | 14 +
 rtl/var_timestep_lpf_mc_update.sv | 44 ++++
 rtl/var_timestep_lpf_mc.sv | 90 +++++++++
 3 files changed

// File: rtl/var_timestep_lpf_mc_pkg.sv
// var_timestep_pkg: shared FSM state type and alpha helpers for var_timestep_lpf_mc.
//   alpha_w(frac)       - width of a clamped alpha with frac fraction bits (0 .. 1.0 inclusive)
//   alpha_clamp(a,frac) - min(a, 2^frac)
package var_timestep_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int alpha_w(input int frac);
    return frac + 1;
  endfunction
  function automatic logic [63:0] alpha_clamp(input logic [63:0] a_raw, input int frac);
    logic [63:0] one;
    one = 64'd1 << frac;
    return a_raw > one ? one : a_raw;
  endfunction
endpackage

// File: rtl/var_timestep_lpf_mc_update.sv
// vt_lpf_update: combinational single-channel step y_new = y + (x - y) * min(dt*k >> K_SHIFT, 1.0).
//   i_y, i_x : signed state and input
//   i_dt     : timestep
//   i_k      : channel coefficient
//   i_en     : channel enable; when low y passes through unchanged
//   o_y_new  : updated state
//   Macro VT_LPF_ROUND_EN selects round-half-up for delta; default is floor.
module vt_lpf_update
  import var_timestep_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DT_WIDTH   = 16,
  parameter int K_WIDTH    = 16,
  parameter int K_SHIFT    = 16,
  parameter int ALPHA_FRAC = 15
) (
  input  logic signed [WIDTH-1:0]    i_y,
  input  logic signed [WIDTH-1:0]    i_x,
  input  logic        [DT_WIDTH-1:0] i_dt,
  input  logic        [K_WIDTH-1:0]  i_k,
  input  logic                       i_en,
  output logic signed [WIDTH-1:0]    o_y_new
);
  localparam int PW = DT_WIDTH + K_WIDTH;
  localparam int AW = alpha_w(ALPHA_FRAC);
  localparam int RW = WIDTH + AW + 2;
  logic        [PW-1:0]  w_a_raw;
  logic        [AW-1:0]  w_alpha;
  logic signed [WIDTH:0] w_diff;
  logic signed [RW-1:0]  w_prod;
  logic signed [RW-1:0]  w_delta;
  assign w_a_raw = (PW'(i_dt) * PW'(i_k)) >> K_SHIFT;
  assign w_alpha = AW'(alpha_clamp(64'(w_a_raw), ALPHA_FRAC));
  assign w_diff  = (WIDTH+1)'(i_x) - (WIDTH+1)'(i_y);
  assign w_prod  = RW'(w_diff) * $signed(RW'(w_alpha));
`ifdef VT_LPF_ROUND_EN
  localparam logic signed [RW-1:0] HALF = RW'(1) << (ALPHA_FRAC - 1);
  assign w_delta = (w_prod + HALF) >>> ALPHA_FRAC;
`else
  assign w_delta = w_prod >>> ALPHA_FRAC;
`endif
  // y_new lies between y and x, so truncating back to WIDTH is lossless
  assign o_y_new = i_en ? WIDTH'(w_delta + RW'(i_y)) : i_y;
endmodule

// File: rtl/var_timestep_lpf_mc.sv
// var_timestep_lpf_mc: multi-channel variable-timestep first-order LPF, one channel per CALC cycle.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : step request handshake (x, dt, k, ch_en sampled on accept)
//   out_valid / out_ready: result handshake (y, t_emu held stable in DONE)
//   y                    : per-channel filter states
//   t_emu                : accumulated dt, wraps modulo 2^T_WIDTH
//   busy                 : FSM not IDLE
//   Macro VT_LPF_ROUND_EN (in vt_lpf_update) switches delta from floor to round-half-up.
module var_timestep_lpf_mc
  import var_timestep_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 16,
  parameter int DT_WIDTH   = 16,
  parameter int K_WIDTH    = 16,
  parameter int K_SHIFT    = 16,
  parameter int ALPHA_FRAC = 15,
  parameter int T_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_CH*WIDTH-1:0]   x,
  input  logic [DT_WIDTH-1:0]     dt,
  input  logic [N_CH*K_WIDTH-1:0] k,
  input  logic [N_CH-1:0]         ch_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*WIDTH-1:0]   y,
  output logic [T_WIDTH-1:0]      t_emu,
  output logic                    busy
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  state_t                    r_state, w_next;
  logic [CW-1:0]             r_ch_idx;
  logic [N_CH*WIDTH-1:0]     r_x, r_y;
  logic [DT_WIDTH-1:0]       r_dt;
  logic [N_CH*K_WIDTH-1:0]   r_k;
  logic [N_CH-1:0]           r_en;
  logic [T_WIDTH-1:0]        r_t;
  logic                      w_last;
  logic signed [WIDTH-1:0]   w_y_new;
  assign w_last = r_ch_idx == CW'(N_CH - 1);
  vt_lpf_update #(
    .WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH), .K_WIDTH(K_WIDTH),
    .K_SHIFT(K_SHIFT), .ALPHA_FRAC(ALPHA_FRAC)
  ) u_update (
    .i_y    (r_y[r_ch_idx*WIDTH +: WIDTH]),
    .i_x    (r_x[r_ch_idx*WIDTH +: WIDTH]),
    .i_dt   (r_dt),
    .i_k    (r_k[r_ch_idx*K_WIDTH +: K_WIDTH]),
    .i_en   (r_en[r_ch_idx]),
    .o_y_new(w_y_new)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (in_valid ? CALC : IDLE) :
             r_state == CALC ? (w_last ? DONE : CALC) :
                               (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ch_idx <= '0;
      r_x      <= '0;
      r_dt     <= '0;
      r_k      <= '0;
      r_en     <= '0;
      r_y      <= '0;
      r_t      <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_ch_idx <= '0;
      r_x      <= x;
      r_dt     <= dt;
      r_k      <= k;
      r_en     <= ch_en;
    end else if (r_state == CALC) begin
      r_y[r_ch_idx*WIDTH +: WIDTH] <= w_y_new;
      r_ch_idx <= w_last ? '0 : r_ch_idx + 1'b1;
      if (w_last) r_t <= r_t + T_WIDTH'(r_dt);
    end
  assign y     = r_y;
  assign t_emu = r_t;
endmodule
